// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes bitstream words over valid/ready and shifts them
// LSB-first into the head of a CCDFF chain. CFGE is raised only once the whole chain is loaded.
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic              START,
    input  logic              ABORT,
    input  logic [WORD_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              CCFF_HEAD,
    output logic              CCFF_SHIFT,
    output logic              CFGE,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [WB_W-1:0]   wbits;
    logic [CNT_W-1:0]  remaining;
    logic              cfge_q;
    logic              error_q;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state     <= S_IDLE;
            sreg      <= '0;
            wbits     <= '0;
            remaining <= '0;
            cfge_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state     <= S_LOAD;
                        remaining <= CNT_W'(CHAIN_LEN);
                        cfge_q    <= 1'b0;
                        error_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Abort beats a same-cycle handshake; the word is dropped.
                    if (ABORT) begin
                        state   <= S_IDLE;
                        error_q <= 1'b1;
                    end else if (DIN_VALID) begin
                        sreg  <= DIN;
                        wbits <= (remaining < CNT_W'(WORD_W)) ? WB_W'(remaining)
                                                               : WB_W'(WORD_W);
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ABORT) begin
                        state   <= S_IDLE;
                        error_q <= 1'b1;
                    end else begin
                        sreg      <= sreg >> 1;
                        wbits     <= wbits - 1'b1;
                        remaining <= remaining - 1'b1;
                        if (wbits == WB_W'(1)) begin
                            if (remaining == CNT_W'(1)) begin
                                state  <= S_DONE;
                                cfge_q <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from registers only, so no input reaches an output combinationally.
    assign DIN_READY  = (state == S_LOAD);
    assign CCFF_SHIFT = (state == S_SHIFT);
    assign CCFF_HEAD  = (state == S_SHIFT) & sreg[0];
    assign BUSY       = (state == S_LOAD) | (state == S_SHIFT);
    assign DONE       = (state == S_DONE);
    assign CFGE       = cfge_q;
    assign ERROR      = error_q;

endmodule
